// File: rtl/fpu_io_pkg.sv
// Shared types and constants for the fpu_io byte-serial front end.
// Optional build macro FPU_IO_STATUS_EN adds a trailing flags byte to every result frame.
package fpu_io_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRxA,
        StRxB,
        StIssue,
        StWait,
        StTx
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int unsigned OPERAND_BYTES = 4;
    localparam int unsigned RESULT_BYTES  = 4;

    // Exception flags {NV, DZ, OF, UF, NX} packed into the low bits of the status byte.
    function automatic logic [7:0] status_byte(input logic [4:0] flags);
        return {3'b000, flags};
    endfunction

endpackage

// File: rtl/fpu_io_if.sv
// Host byte channels plus the FPU core issue/completion bus of the fpu_io front end.
// The slave modport is the sequencer side; master is the host/core side.
interface fpu_io_if;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;

    modport master (
        output in_data, in_valid, out_ready, fpu_done, fpu_result, fpu_flags,
        input  in_ready, out_data, out_valid, fpu_op, fpu_a, fpu_b, fpu_start
    );

    modport slave (
        input  in_data, in_valid, out_ready, fpu_done, fpu_result, fpu_flags,
        output in_ready, out_data, out_valid, fpu_op, fpu_a, fpu_b, fpu_start
    );

endinterface

// File: rtl/fpu_io_serializer.sv
// Result holding register that presents one byte at a time, most significant byte first.
// With FPU_IO_STATUS_EN the loaded word is one byte wider (flags appended by the top).
module fpu_io_serializer
    import fpu_io_pkg::*;
#(
    parameter int unsigned NumBytes = RESULT_BYTES,
    parameter int unsigned IdxW     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [8*NumBytes-1:0] word,
    input  logic [IdxW-1:0]       idx,
    output logic [7:0]            data,
    output logic                  last
);

    logic [8*NumBytes-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= word;
        end
    end

    // Index 0 selects the most significant byte.
    always_comb begin
        data = 8'h00;
        for (int unsigned i = 0; i < NumBytes; i++) begin
            if (idx == IdxW'(i)) begin
                data = word_q[8*(NumBytes-1-i) +: 8];
            end
        end
    end

    assign last = (idx == IdxW'(NumBytes - 1));

endmodule

// File: rtl/fpu_io_sequencer.sv
// Byte-serial front end: collects opcode + two operands, issues one FPU op, streams result back.
// Define FPU_IO_STATUS_EN to append a {3'b000, flags} byte after the 32-bit result.
module fpu_io_sequencer #(
    parameter int unsigned RESULT_BYTES = fpu_io_pkg::RESULT_BYTES
) (
    input logic     clk,
    input logic     rst,
    input logic     ena,
    fpu_io_if.slave bus
);

    import fpu_io_pkg::*;

`ifdef FPU_IO_STATUS_EN
    localparam int unsigned OutBytes = RESULT_BYTES + 1;
    localparam int unsigned IdxW     = 3;
`else
    localparam int unsigned OutBytes = RESULT_BYTES;
    localparam int unsigned IdxW     = 2;
`endif

    localparam logic [IdxW-1:0] OperandLast = IdxW'(OPERAND_BYTES - 1);

    state_e                state_q;
    logic [IdxW-1:0]       byte_idx_q;
    logic [1:0]            op_q;
    logic [31:0]           a_q;
    logic [31:0]           b_q;
    logic                  start_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic                  in_fire;
    logic                  out_fire;
    logic                  load;
    logic                  last;
    logic [8*OutBytes-1:0] load_word;

    assign in_fire  = ena & bus.in_valid & in_ready_q;
    assign out_fire = ena & out_valid_q & bus.out_ready;
    // Completion outside StWait (stray or from an aborted frame) is dropped here.
    assign load     = ena & bus.fpu_done & (state_q == StWait);

`ifdef FPU_IO_STATUS_EN
    assign load_word = {bus.fpu_result, status_byte(bus.fpu_flags)};
`else
    logic unused_flags;
    assign unused_flags = ^bus.fpu_flags;
    assign load_word    = bus.fpu_result;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_idx_q  <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                StIdle: begin
                    if (in_fire) begin
                        op_q       <= bus.in_data[1:0];
                        byte_idx_q <= '0;
                        state_q    <= StRxA;
                    end
                end
                StRxA: begin
                    if (in_fire) begin
                        a_q <= {a_q[23:0], bus.in_data};
                        if (byte_idx_q == OperandLast) begin
                            byte_idx_q <= '0;
                            state_q    <= StRxB;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
                StRxB: begin
                    if (in_fire) begin
                        b_q <= {b_q[23:0], bus.in_data};
                        if (byte_idx_q == OperandLast) begin
                            byte_idx_q <= '0;
                            start_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= StIssue;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    start_q    <= 1'b0;
                    byte_idx_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (load) begin
                        byte_idx_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StTx;
                    end
                end
                StTx: begin
                    if (out_fire) begin
                        if (last) begin
                            byte_idx_q  <= '0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    fpu_io_serializer #(
        .NumBytes(OutBytes),
        .IdxW    (IdxW)
    ) u_serializer (
        .clk (clk),
        .rst (rst),
        .load(load),
        .word(load_word),
        .idx (byte_idx_q),
        .data(bus.out_data),
        .last(last)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fpu_start = start_q;
    assign bus.fpu_op    = op_q;
    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;

    // Start may be held through ena-low cycles but never survives an enabled edge.
    start_single: assert property (@(posedge clk) disable iff (rst)
        (start_q && ena) |=> !start_q);
    out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !(ena && bus.out_ready)) |=> $stable(bus.out_data));
    channel_excl: assert property (@(posedge clk) disable iff (rst)
        !(in_ready_q && out_valid_q));

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Self-checking bench for fpu_io_sequencer with a latency-configurable FPU core model.
// Build with FPU_IO_STATUS_EN defined to also cover the trailing status byte.
module tb_fpu_io_sequencer;

`ifdef FPU_IO_STATUS_EN
    localparam int NOUT = 5;
`else
    localparam int NOUT = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;

    always #5 clk = ~clk;

    fpu_io_if bus ();

    fpu_io_sequencer #(
        .RESULT_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .bus(bus.slave)
    );

    int passed;
    int total;

    // Core model configuration (written by tests only).
    int          core_lat;
    logic [31:0] core_result;
    logic [4:0]  core_flags;
    int          stray_req_cnt;

    // Core model observations (written by the model only).
    int          cyc;
    int          start_cnt;
    int          done_cyc;
    int          core_cnt;
    int          stray_seen;
    logic [1:0]  seen_op;
    logic [31:0] seen_a, seen_b, a_at_done, b_at_done;

    initial begin
        bit take;
        cyc = 0; start_cnt = 0; done_cyc = -10; core_cnt = 0; stray_seen = 0;
        seen_op = '0; seen_a = '0; seen_b = '0; a_at_done = '0; b_at_done = '0;
        bus.fpu_done = 1'b0; bus.fpu_result = '0; bus.fpu_flags = '0;
        forever begin
            @(posedge clk);
            cyc++;
            take = ena && !rst && (bus.fpu_start === 1'b1);
            #1;
            bus.fpu_done = 1'b0;
            if (take) begin
                start_cnt++;
                seen_op  = bus.fpu_op;
                seen_a   = bus.fpu_a;
                seen_b   = bus.fpu_b;
                core_cnt = core_lat;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.fpu_done   = 1'b1;
                    bus.fpu_result = core_result;
                    bus.fpu_flags  = core_flags;
                    done_cyc       = cyc;
                    a_at_done      = bus.fpu_a;
                    b_at_done      = bus.fpu_b;
                end
            end
            if (stray_seen != stray_req_cnt) begin
                stray_seen     = stray_req_cnt;
                bus.fpu_done   = 1'b1;
                bus.fpu_result = 32'hDEADBEEF;
                bus.fpu_flags  = 5'h1F;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] r, input logic [4:0] f,
                                            input int k);
        logic [31:0] s;
        if (k >= 4) return {3'b000, f};
        s = r >> (8 * (3 - k));
        return s[7:0];
    endfunction

    task automatic send_frame(input string name, input logic [7:0] opb, input logic [31:0] a,
                              input logic [31:0] b, input int max_gap, output int first_cyc);
        logic [7:0]  fb [9];
        logic [31:0] t;
        int          base, w, gap;
        fb[0] = opb;
        for (int j = 0; j < 4; j++) begin
            t = a >> (8 * (3 - j)); fb[1+j] = t[7:0];
            t = b >> (8 * (3 - j)); fb[5+j] = t[7:0];
        end
        base = start_cnt;
        first_cyc = 0;
        for (int i = 0; i < 9; i++) begin
            gap = $urandom_range(0, max_gap);
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = fb[i];
            w = 0;
            while (bus.in_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
            @(negedge clk);
            if (i == 0) first_cyc = cyc;
            total++;
            if (i < 8) begin
                if ({bus.in_ready, bus.fpu_start} !== 2'b10 || start_cnt != base) begin
                    $display("FAIL %s rx_byte%0d: in_ready,start=%b%b starts=%0d want 10 starts=%0d",
                             name, i, bus.in_ready, bus.fpu_start, start_cnt, base);
                end else passed++;
            end else begin
                if ({bus.in_ready, bus.fpu_start} !== 2'b01) begin
                    $display("FAIL %s issue_latency: in_ready,start=%b%b want 01",
                             name, bus.in_ready, bus.fpu_start);
                end else passed++;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [31:0] r, input logic [4:0] f,
                        input int mode);
        int         w, k, i;
        logic       rdy;
        logic [7:0] e;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 300) begin
            total++;
            if (bus.in_ready !== 1'b0) begin
                $display("FAIL %s busy_in_ready: got %b want 0", name, bus.in_ready);
            end else passed++;
            @(negedge clk); w++;
        end
        total++;
        if (bus.out_valid !== 1'b1 || cyc != done_cyc + 1) begin
            $display("FAIL %s return_latency: out_valid=%b at cyc %0d, want 1 at cyc %0d",
                     name, bus.out_valid, cyc, done_cyc + 1);
            return;
        end else passed++;
        k = 0; i = 0;
        while (k < NOUT && i < 200) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ((i % 4) == 0) || ((i % 4) == 3);
            else rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            e = exp_byte(r, f, k);
            total++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, e}) begin
                $display("FAIL %s out_byte%0d: valid,data=%b,%h want 1,%h",
                         name, k, bus.out_valid, bus.out_data, e);
                break;
            end else passed++;
            if (rdy) k++;
            @(negedge clk); i++;
        end
        bus.out_ready = 1'b0;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01 || k != NOUT) begin
            $display("FAIL %s turnaround: out_valid,in_ready=%b%b bytes=%0d want 01 bytes=%0d",
                     name, bus.out_valid, bus.in_ready, k, NOUT);
        end else passed++;
    endtask

    task automatic run_frame(input string name, input logic [7:0] opb, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] r, input logic [4:0] f,
                             input int lat, input int max_gap, input int mode,
                             output int first_cyc);
        int base;
        base = start_cnt;
        core_lat = lat; core_result = r; core_flags = f;
        send_frame(name, opb, a, b, max_gap, first_cyc);
        recv(name, r, f, mode);
        total++;
        if ({32'(start_cnt - base), seen_op, seen_a, seen_b, a_at_done, b_at_done}
            !== {32'd1, opb[1:0], a, b, a, b}) begin
            $display("FAIL %s issue_operands: starts=%0d op=%0d a=%h b=%h a@done=%h b@done=%h want starts=1 op=%0d a=%h b=%h",
                     name, start_cnt - base, seen_op, seen_a, seen_b, a_at_done, b_at_done,
                     opb[1:0], a, b);
        end else passed++;
    endtask

    task automatic check_reset_vector(input string name);
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.fpu_start, bus.fpu_op,
             bus.fpu_a, bus.fpu_b} !== {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 32'h0, 32'h0}) begin
            $display("FAIL %s reset_values: in_ready=%b out_valid=%b out_data=%h start=%b op=%0d a=%h b=%h want 1 0 00 0 0 0 0",
                     name, bus.in_ready, bus.out_valid, bus.out_data, bus.fpu_start,
                     bus.fpu_op, bus.fpu_a, bus.fpu_b);
        end else passed++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vector("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vector("reset_released");
    endtask

    task automatic test_add();
        int fc;
        run_frame("add", 8'h00, 32'h3F800000, 32'h40000000, 32'h40400000, 5'h00, 3, 0, 0, fc);
    endtask

    task automatic test_backpressure();
        int fc;
        run_frame("div_bp", 8'h03, $urandom, $urandom, $urandom, 5'($urandom), 4, 0, 1, fc);
    endtask

    task automatic test_input_gaps();
        int fc;
        for (int n = 0; n < 3; n++) begin
            run_frame("gaps", 8'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                      $urandom_range(1, 5), 5, 0, fc);
        end
    endtask

    task automatic test_stray_done();
        int fc;
        stray_req_cnt++;
        repeat (5) begin
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                $display("FAIL stray_done idle: out_valid,in_ready=%b%b want 01",
                         bus.out_valid, bus.in_ready);
            end else passed++;
        end
        run_frame("after_stray", 8'h01, $urandom, $urandom, $urandom, 5'h00, 2, 1, 0, fc);
    endtask

    task automatic test_reset_in_wait();
        int base, w, fc;
        base = start_cnt;
        core_lat = 6; core_result = $urandom; core_flags = 5'h04;
        send_frame("rst_wait", 8'h02, $urandom, $urandom, 0, fc);
        w = 0;
        while (start_cnt == base && w < 20) begin @(negedge clk); w++; end
        total++;
        if (start_cnt != base + 1) begin
            $display("FAIL rst_wait start_seen: starts=%0d want %0d", start_cnt - base, 1);
        end else passed++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vector("rst_wait_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_reset_vector("rst_wait_after");
        end
        run_frame("after_rst", 8'h00, $urandom, $urandom, $urandom, 5'h00, 1, 0, 0, fc);
    endtask

    task automatic test_ena_freeze();
        int base, fc;
        logic [31:0] r;
        base = start_cnt;
        r = $urandom;
        core_lat = 2; core_result = r; core_flags = 5'h02;
        send_frame("ena", 8'h02, 32'h12345678, 32'h9ABCDEF0, 0, fc);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({bus.fpu_start, bus.in_ready, bus.out_valid} !== 3'b100 || start_cnt != base) begin
                $display("FAIL ena_freeze: start,in_ready,out_valid=%b%b%b starts=%0d want 100 starts=0",
                         bus.fpu_start, bus.in_ready, bus.out_valid, start_cnt - base);
            end else passed++;
        end
        ena = 1'b1;
        recv("ena", r, 5'h02, 0);
        total++;
        if ({32'(start_cnt - base), seen_a, seen_b} !== {32'd1, 32'h12345678, 32'h9ABCDEF0}) begin
            $display("FAIL ena_single_start: starts=%0d a=%h b=%h want 1 12345678 9abcdef0",
                     start_cnt - base, seen_a, seen_b);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int fc0, fc1;
        run_frame("b2b_0", 8'h00, $urandom, $urandom, $urandom, 5'h00, 2, 0, 0, fc0);
        run_frame("b2b_1", 8'h02, $urandom, $urandom, $urandom, 5'h01, 2, 0, 0, fc1);
        total++;
        if (fc1 - fc0 != 9 + 1 + 2 + 1 + NOUT) begin
            $display("FAIL b2b frame_period: got %0d want %0d", fc1 - fc0, 9 + 1 + 2 + 1 + NOUT);
        end else passed++;
    endtask

    task automatic test_random();
        int fc;
        for (int n = 0; n < 8; n++) begin
            run_frame("rand", 8'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                      $urandom_range(1, 6), 3, 2, fc);
        end
    endtask

`ifdef FPU_IO_STATUS_EN
    task automatic test_status();
        int fc;
        run_frame("status", 8'h03, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000,
                  3, 0, 0, fc);
    endtask
`endif

    initial begin
        passed = 0; total = 0;
        core_lat = 3; core_result = '0; core_flags = '0; stray_req_cnt = 0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_input_gaps();
        test_stray_done();
        test_reset_in_wait();
        test_ena_freeze();
        test_back_to_back();
        test_random();
`ifdef FPU_IO_STATUS_EN
        test_status();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
